// File: rtl/router_out_scheduler.sv
// ============================================================================
// Module   : router_out_scheduler
// Captures one packet per ingress port into a holding slot and round-robin
// schedules the slots onto eight addressed output registers (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_out_scheduler #(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3*NUM_IN-1:0]   in_addr,
  input  logic [DATA_W*NUM_IN-1:0] in_data,
  input  logic [NUM_IN-1:0]     in_valid,
  output logic [NUM_IN-1:0]     in_drop,
  output logic [7:0]            out_valid,
  output logic [DATA_W*8-1:0]   out_data,
  output logic [SRC_W*8-1:0]    out_src,
  input  logic [7:0]            out_ready,
  output logic                  busy
);

  logic [2:0]        in_addr_w [NUM_IN];
  logic [DATA_W-1:0] in_data_w [NUM_IN];

  logic [NUM_IN-1:0] prev_q, occ_q, occ_d, drop_q, drop_d, grant_slot;
  logic [2:0]        addr_q  [NUM_IN];
  logic [2:0]        addr_d  [NUM_IN];
  logic [DATA_W-1:0] sdata_q [NUM_IN];
  logic [DATA_W-1:0] sdata_d [NUM_IN];

  logic [7:0]        ov_q, ov_d, found_w;
  logic [DATA_W-1:0] od_q [8];
  logic [DATA_W-1:0] od_d [8];
  logic [SRC_W-1:0]  os_q [8];
  logic [SRC_W-1:0]  os_d [8];
  logic [SRC_W-1:0]  rr_q [8];
  logic [SRC_W-1:0]  rr_d [8];
  logic [SRC_W-1:0]  win_w [8];
  logic [SRC_W-1:0]  idx;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign in_addr_w[i] = in_addr[3*i +: 3];
    assign in_data_w[i] = in_data[DATA_W*i +: DATA_W];
  end

  for (genvar o = 0; o < 8; o++) begin : g_out
    assign out_data[DATA_W*o +: DATA_W] = od_q[o];
    assign out_src[SRC_W*o +: SRC_W]    = os_q[o];
  end

  assign in_drop   = drop_q;
  assign out_valid = ov_q;
  assign busy      = (|occ_q) | (|ov_q);

  // Rotating priority search per destination, starting at its rr pointer.
  always_comb begin
    idx     = '0;
    found_w = '0;
    for (int o = 0; o < 8; o++) begin
      win_w[o] = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        idx = SRC_W'((int'(rr_q[o]) + k) % NUM_IN);
        if (!found_w[o] && occ_q[idx] && (addr_q[idx] == 3'(o))) begin
          found_w[o] = 1'b1;
          win_w[o]   = idx;
        end
      end
    end
  end

  always_comb begin
    occ_d      = occ_q;
    drop_d     = '0;
    ov_d       = ov_q;
    grant_slot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      addr_d[i]  = addr_q[i];
      sdata_d[i] = sdata_q[i];
    end
    for (int o = 0; o < 8; o++) begin
      od_d[o] = od_q[o];
      os_d[o] = os_q[o];
      rr_d[o] = rr_q[o];
      if (!ov_q[o] || out_ready[o]) begin
        ov_d[o] = found_w[o];
        if (found_w[o]) begin
          od_d[o]              = sdata_q[win_w[o]];
          os_d[o]              = win_w[o];
          rr_d[o]              = SRC_W'((int'(win_w[o]) + 1) % NUM_IN);
          grant_slot[win_w[o]] = 1'b1;
        end
      end
    end
    // A slot granted this cycle may be refilled in the same cycle.
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_slot[i]) occ_d[i] = 1'b0;
      if (in_valid[i] && !prev_q[i]) begin
        if (!occ_q[i] || grant_slot[i]) begin
          occ_d[i]   = 1'b1;
          addr_d[i]  = in_addr_w[i];
          sdata_d[i] = in_data_w[i];
        end else begin
          drop_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    prev_q <= in_valid;
    if (reset) begin
      occ_q  <= '0;
      drop_q <= '0;
      ov_q   <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        addr_q[i]  <= '0;
        sdata_q[i] <= '0;
      end
      for (int o = 0; o < 8; o++) begin
        od_q[o] <= '0;
        os_q[o] <= '0;
        rr_q[o] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      drop_q <= drop_d;
      ov_q   <= ov_d;
      for (int i = 0; i < NUM_IN; i++) begin
        addr_q[i]  <= addr_d[i];
        sdata_q[i] <= sdata_d[i];
      end
      for (int o = 0; o < 8; o++) begin
        od_q[o] <= od_d[o];
        os_q[o] <= os_d[o];
        rr_q[o] <= rr_d[o];
      end
    end
  end

endmodule

`default_nettype wire
